// File: rtl/lc4_store_buffer_if.sv
// Memory-stage <-> store buffer bundle, including the dmem port the buffer owns.
// master = memory stage / dmem side, slave = lc4_store_buffer.
interface lc4_store_buffer_if #(parameter int AW = 2);
  logic        gwe;
  logic        st_valid;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        ld_valid;
  logic [15:0] ld_addr;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic        ld_conflict;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_in;
  logic        dmem_we;

  modport master (
    output gwe, st_valid, st_addr, st_data, ld_valid, ld_addr,
    input  full, empty, count, fwd_hit, fwd_data, ld_conflict,
           dmem_addr, dmem_in, dmem_we
  );

  modport slave (
    input  gwe, st_valid, st_addr, st_data, ld_valid, ld_addr,
    output full, empty, count, fwd_hit, fwd_data, ld_conflict,
           dmem_addr, dmem_in, dmem_we
  );
endinterface

// File: rtl/lc4_store_buffer.sv
// LC4 store buffer: FIFO of stores drained into idle dmem cycles, with load hazard check.
// Define STORE_FWD_EN to forward matching store data instead of raising ld_conflict.
module lc4_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic            clk,
  input logic            rst,
  lc4_store_buffer_if.slave sb
);

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } sb_ent_t;

  sb_ent_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [AW:0]         cnt_q, cnt_d;

  logic full, empty, drain, push, pop;
  logic hit;
  logic [AW-1:0] idx;
`ifdef STORE_FWD_EN
  logic [15:0] hit_data;
`endif

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  // Reset cycle never drains, so nothing reaches dmem while stores are discarded.
  assign drain = !rst && !sb.ld_valid && !empty;
  assign push  = !rst && sb.gwe && sb.st_valid && !full;
  assign pop   = drain && sb.gwe;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[tail_q] = '{addr: sb.st_addr, data: sb.st_data};
      tail_d        = tail_q + AW'(1);
    end
    if (pop) head_d = head_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Walk oldest to youngest so the last match seen is the one nearest tail.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef STORE_FWD_EN
    hit_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + AW'(k);
      if (((AW+1)'(k) < cnt_q) && (mem_q[idx].addr == sb.ld_addr)) begin
        hit = 1'b1;
`ifdef STORE_FWD_EN
        hit_data = mem_q[idx].data;
`endif
      end
    end
  end

`ifdef STORE_FWD_EN
  assign sb.fwd_hit     = sb.ld_valid && hit;
  assign sb.fwd_data    = sb.fwd_hit ? hit_data : 16'h0000;
  assign sb.ld_conflict = 1'b0;
`else
  assign sb.fwd_hit     = 1'b0;
  assign sb.fwd_data    = 16'h0000;
  assign sb.ld_conflict = sb.ld_valid && hit;
`endif

  always_comb begin
    sb.dmem_addr = 16'h0000;
    sb.dmem_in   = 16'h0000;
    sb.dmem_we   = 1'b0;
    if (sb.ld_valid) begin
      sb.dmem_addr = sb.ld_addr;
    end else if (drain) begin
      sb.dmem_addr = mem_q[head_q].addr;
      sb.dmem_in   = mem_q[head_q].data;
      sb.dmem_we   = sb.gwe;
    end
  end

  assign sb.full  = full;
  assign sb.empty = empty;
  assign sb.count = cnt_q;

endmodule

// File: tb/tb_lc4_store_buffer.sv
// Store buffer bench: directed scenarios plus random traffic, checked against a queue model.
module tb_lc4_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lc4_store_buffer_if #(.AW(AW)) sb_if ();

  lc4_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] aq[$];
  logic [15:0] dq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model.
  task automatic cyc(input bit r, input bit g, input bit sv, input logic [15:0] sa,
                     input logic [15:0] sd, input bit lv, input logic [15:0] la);
    int n;
    bit e_drain, e_hit;
    logic [15:0] e_fd, e_addr, e_in;
    @(negedge clk);
    rst = r;
    sb_if.gwe = g; sb_if.st_valid = sv; sb_if.st_addr = sa; sb_if.st_data = sd;
    sb_if.ld_valid = lv; sb_if.ld_addr = la;
    #1;
    n = aq.size();
    e_drain = !r && !lv && (n > 0);
    e_hit = 1'b0;
    e_fd = 16'h0;
    if (lv) for (int i = 0; i < n; i++) if (aq[i] == la) begin e_hit = 1'b1; e_fd = dq[i]; end
    e_addr = lv ? la : (e_drain ? aq[0] : 16'h0);
    e_in   = (!lv && e_drain) ? dq[0] : 16'h0;
    chk("count", sb_if.count, n);
    chk("empty", sb_if.empty, n == 0);
    chk("full", sb_if.full, n == DEPTH);
    chk("dmem_we", sb_if.dmem_we, e_drain && g);
    chk("dmem_addr", sb_if.dmem_addr, e_addr);
    chk("dmem_in", sb_if.dmem_in, e_in);
`ifdef STORE_FWD_EN
    chk("fwd_hit", sb_if.fwd_hit, e_hit);
    chk("fwd_data", sb_if.fwd_data, e_hit ? e_fd : 16'h0);
    chk("ld_conflict", sb_if.ld_conflict, 0);
`else
    chk("fwd_hit", sb_if.fwd_hit, 0);
    chk("fwd_data", sb_if.fwd_data, 0);
    chk("ld_conflict", sb_if.ld_conflict, e_hit);
`endif
    if (r) begin
      aq.delete(); dq.delete();
    end else if (g) begin
      bit acc;
      acc = sv && (n < DEPTH);
      if (e_drain) begin void'(aq.pop_front()); void'(dq.pop_front()); end
      if (acc) begin aq.push_back(sa); dq.push_back(sd); end
    end
  endtask

  task automatic idle();
    cyc(0, 1, 0, 16'h0, 16'h0, 0, 16'h0);
  endtask

  initial begin
    sb_if.gwe = 1'b0; sb_if.st_valid = 1'b0; sb_if.st_addr = '0; sb_if.st_data = '0;
    sb_if.ld_valid = 1'b0; sb_if.ld_addr = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: reset then idle
    cyc(1, 1, 0, 16'h0, 16'h0, 0, 16'h0);
    idle();
    chk("t1_empty", sb_if.empty, 1);
    chk("t1_addr", sb_if.dmem_addr, 0);

    // 2: single store drains the next cycle
    cyc(0, 1, 1, 16'h4000, 16'hBEEF, 0, 16'h0);
    idle();
    chk("t2_we", sb_if.dmem_we, 1);
    chk("t2_addr", sb_if.dmem_addr, 16'h4000);
    chk("t2_in", sb_if.dmem_in, 16'hBEEF);
    idle();
    chk("t2_empty", sb_if.empty, 1);

    // 3: fill under loads, 5th store rejected, push at full in a pop cycle rejected
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 16'h10 + 16'(i), 16'hA0 + 16'(i), 1, 16'h100);
    cyc(0, 1, 1, 16'h14, 16'hA4, 0, 16'h0);
    chk("t3_full", sb_if.full, 1);
    chk("t3_drain0", sb_if.dmem_addr, 16'h10);
    for (int i = 1; i < 4; i++) begin
      idle();
      chk("t3_drain", sb_if.dmem_addr, 16'h10 + 16'(i));
    end
    idle();
    chk("t3_empty", sb_if.empty, 1);

`ifdef STORE_FWD_EN
    // 4: forwarding picks the youngest match
    cyc(0, 1, 1, 16'h20, 16'h1111, 1, 16'h100);
    cyc(0, 1, 1, 16'h20, 16'h2222, 1, 16'h100);
    cyc(0, 1, 0, 16'h0, 16'h0, 1, 16'h20);
    chk("t4_hit", sb_if.fwd_hit, 1);
    chk("t4_data", sb_if.fwd_data, 16'h2222);
    cyc(0, 1, 0, 16'h0, 16'h0, 1, 16'h21);
    chk("t4_miss", sb_if.fwd_hit, 0);
    repeat (3) idle();
`else
    // 5: conflict stalls the load until the store drains
    cyc(0, 1, 1, 16'h30, 16'h0005, 1, 16'h100);
    cyc(0, 1, 0, 16'h0, 16'h0, 1, 16'h30);
    chk("t5_conf", sb_if.ld_conflict, 1);
    idle();
    cyc(0, 1, 0, 16'h0, 16'h0, 1, 16'h30);
    chk("t5_clear", sb_if.ld_conflict, 0);
    chk("t5_addr", sb_if.dmem_addr, 16'h30);
`endif

    // 6: gwe freeze then reset mid-drain
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 16'h50 + 16'(i), 16'h7000 + 16'(i), 1, 16'h100);
    repeat (2) begin
      cyc(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
      chk("t6_we", sb_if.dmem_we, 0);
      chk("t6_cnt", sb_if.count, 3);
    end
    cyc(1, 1, 0, 16'h0, 16'h0, 0, 16'h0);
    chk("t6_rst_we", sb_if.dmem_we, 0);
    idle();
    chk("t6_cnt0", sb_if.count, 0);
    chk("t6_we0", sb_if.dmem_we, 0);

    // random traffic
    for (int c = 0; c < 800; c++) begin
      cyc(($urandom % 64) == 0, ($urandom % 8) != 0, $urandom % 2,
          16'h40 + 16'($urandom % 6), 16'($urandom), ($urandom % 3) == 0,
          16'h40 + 16'($urandom % 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
